// File: rtl/sccb_master.sv
// sccb_master: SCCB / I2C-compatible bit-level master. Executes one 3-phase
// register write, or one 2-phase-write / 2-phase-read register read, per
// accepted request. Drives push-pull SCL and open-drain SDA (via sda_oe).
//
// Optional feature macro: SCCB_ACK_CHECK_EN
//    defined   - ACK slots are evaluated; a NACK sets ack_err and aborts the
//                transaction through STOP.
//    undefined - ACK slots are clocked as SCCB don't-care bits; ack_err stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus released, waiting for ena
// START   | start / repeated start condition (4 ticks)
// TX_BYTE | shift out 8 bits, MSB first
// ACK     | SDA released, slave drives the ninth bit
// RX_BYTE | sample 8 bits from the slave, MSB first
// MACK    | master NACK (SDA released) after the read byte
// STOP    | stop condition (4 ticks); may chain into the read phase
module sccb_master #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] addr,
   input  logic [7:0] sub_addr,
   input  logic [7:0] data_wr,
   input  logic       rw,
   output logic       busy,
   output logic       ack_err,
   output logic [7:0] data_rd,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] TICK_LOAD = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_TX_BYTE,
      S_ACK,
      S_RX_BYTE,
      S_MACK,
      S_STOP
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  tick_cnt, tick_nxt;
   logic [1:0]     qtr, qtr_nxt;
   logic [2:0]     bit_cnt, bit_nxt;
   logic [1:0]     byte_sel, sel_nxt;
   logic           rd_phase2, phase2_nxt;
   logic [7:0]     addr_q, addr_nxt;
   logic [7:0]     sub_q, sub_nxt;
   logic [7:0]     data_q, data_nxt;
   logic           rw_q, rw_nxt;
   logic [7:0]     tx_sh, tx_nxt;
   logic [7:0]     rx_sh, rx_nxt;
   logic           busy_nxt, ack_err_nxt;
   logic [7:0]     data_rd_nxt;
   logic           scl_nxt, sda_oe_nxt;
   logic           tick;
   logic           scl_mid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state, datapath and pin decode.
   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick_cnt;
      qtr_nxt     = qtr;
      bit_nxt     = bit_cnt;
      sel_nxt     = byte_sel;
      phase2_nxt  = rd_phase2;
      addr_nxt    = addr_q;
      sub_nxt     = sub_q;
      data_nxt    = data_q;
      rw_nxt      = rw_q;
      tx_nxt      = tx_sh;
      rx_nxt      = rx_sh;
      busy_nxt    = busy;
      ack_err_nxt = ack_err;
      data_rd_nxt = data_rd;
      scl_nxt     = 1'b1;
      sda_oe_nxt  = 1'b0;
      tick        = (tick_cnt == '0);
      scl_mid     = (qtr == 2'd1) || (qtr == 2'd2);

      // Pins follow the current slot; they are registered to stay glitch-free.
      case (state)
         S_START: begin
            scl_nxt    = (qtr <= 2'd1);
            sda_oe_nxt = (qtr != 2'd0);
         end
         S_TX_BYTE: begin
            scl_nxt    = scl_mid;
            sda_oe_nxt = ~tx_sh[7];
         end
         S_ACK, S_RX_BYTE, S_MACK: begin
            scl_nxt    = scl_mid;
         end
         S_STOP: begin
            scl_nxt    = (qtr != 2'd0);
            sda_oe_nxt = (qtr <= 2'd1);
         end
         default: ;
      endcase

      if (state == S_IDLE) begin
         if (ena) begin
            addr_nxt    = addr;
            sub_nxt     = sub_addr;
            data_nxt    = data_wr;
            rw_nxt      = rw;
            busy_nxt    = 1'b1;
            ack_err_nxt = 1'b0;
            phase2_nxt  = 1'b0;
            tick_nxt    = TICK_LOAD;
            qtr_nxt     = 2'd0;
            state_nxt   = S_START;
         end
      end else if (tick) begin
         tick_nxt = TICK_LOAD;
         qtr_nxt  = qtr + 2'd1;

         if (qtr == 2'd2 && state == S_RX_BYTE)
            rx_nxt = {rx_sh[6:0], sda_in};
`ifdef SCCB_ACK_CHECK_EN
         if (qtr == 2'd2 && state == S_ACK && sda_in)
            ack_err_nxt = 1'b1;
`endif

         if (qtr == 2'd3) begin
            case (state)
               S_START: begin
                  // Device address with the R/W bit substituted into bit 0.
                  tx_nxt    = addr_q;
                  tx_nxt[0] = rd_phase2;
                  bit_nxt   = 3'd7;
                  sel_nxt   = 2'd0;
                  state_nxt = S_TX_BYTE;
               end
               S_TX_BYTE: begin
                  if (bit_cnt == 3'd0) begin
                     state_nxt = S_ACK;
                  end else begin
                     bit_nxt = bit_cnt - 3'd1;
                     tx_nxt  = {tx_sh[6:0], 1'b0};
                  end
               end
               S_ACK: begin
                  // ack_err can only be set here when the ACK check is built in.
                  if (ack_err) begin
                     state_nxt = S_STOP;
                  end else begin
                     case (byte_sel)
                        2'd0: begin
                           bit_nxt = 3'd7;
                           if (rd_phase2) begin
                              state_nxt = S_RX_BYTE;
                           end else begin
                              tx_nxt    = sub_q;
                              sel_nxt   = 2'd1;
                              state_nxt = S_TX_BYTE;
                           end
                        end
                        2'd1: begin
                           if (rw_q) begin
                              state_nxt = S_STOP;
                           end else begin
                              tx_nxt    = data_q;
                              bit_nxt   = 3'd7;
                              sel_nxt   = 2'd2;
                              state_nxt = S_TX_BYTE;
                           end
                        end
                        default: state_nxt = S_STOP;
                     endcase
                  end
               end
               S_RX_BYTE: begin
                  if (bit_cnt == 3'd0) state_nxt = S_MACK;
                  else                 bit_nxt   = bit_cnt - 3'd1;
               end
               S_MACK: begin
                  data_rd_nxt = rx_sh;
                  state_nxt   = S_STOP;
               end
               S_STOP: begin
                  // A read chains phase 1 into phase 2 unless it was aborted.
                  if (rw_q && !rd_phase2 && !ack_err) begin
                     phase2_nxt = 1'b1;
                     state_nxt  = S_START;
                  end else begin
                     busy_nxt  = 1'b0;
                     state_nxt = S_IDLE;
                  end
               end
               default: state_nxt = S_IDLE;
            endcase
         end
      end else begin
         tick_nxt = tick_cnt - CW'(1);
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         qtr       <= 2'd0;
         bit_cnt   <= 3'd0;
         byte_sel  <= 2'd0;
         rd_phase2 <= 1'b0;
         addr_q    <= 8'h00;
         sub_q     <= 8'h00;
         data_q    <= 8'h00;
         rw_q      <= 1'b0;
         tx_sh     <= 8'h00;
         rx_sh     <= 8'h00;
         busy      <= 1'b0;
         ack_err   <= 1'b0;
         data_rd   <= 8'h00;
         scl       <= 1'b1;
         sda_oe    <= 1'b0;
      end else begin
         tick_cnt  <= tick_nxt;
         qtr       <= qtr_nxt;
         bit_cnt   <= bit_nxt;
         byte_sel  <= sel_nxt;
         rd_phase2 <= phase2_nxt;
         addr_q    <= addr_nxt;
         sub_q     <= sub_nxt;
         data_q    <= data_nxt;
         rw_q      <= rw_nxt;
         tx_sh     <= tx_nxt;
         rx_sh     <= rx_nxt;
         busy      <= busy_nxt;
         ack_err   <= ack_err_nxt;
         data_rd   <= data_rd_nxt;
         scl       <= scl_nxt;
         sda_oe    <= sda_oe_nxt;
      end
   end

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: directed bench for sccb_master with a behavioural SCCB
// slave / bus monitor. Bus events are logged as START, STOP or {byte, ack}.
module tb_sccb_master;

   localparam int EV_START = 'h1000;
   localparam int EV_STOP  = 'h2000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] addr, sub_addr, data_wr;
   logic       rw;
   logic       busy, ack_err, scl, sda_oe;
   logic [7:0] data_rd;
   logic       sda_in;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic ack_after_acc;

   // slave / monitor state
   logic       scl_prev = 1'b1;
   logic       sda_prev = 1'b1;
   logic [8:0] mon_sh = '0;
   int         mon_bit = 0;
   int         mon_byte = 0;
   logic       mon_act = 1'b0;
   logic       mon_read = 1'b0;
   logic       slave_pull = 1'b0;
   logic [7:0] slave_rd_byte = 8'h00;
   int         slave_nack_byte = -1;
   int         bus_log[$];

   wire sda_line = ~(sda_oe | slave_pull);
   assign sda_in = sda_line;

   sccb_master #(.CLK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .addr     (addr),
      .sub_addr (sub_addr),
      .data_wr  (data_wr),
      .rw       (rw),
      .busy     (busy),
      .ack_err  (ack_err),
      .data_rd  (data_rd),
      .scl      (scl),
      .sda_oe   (sda_oe),
      .sda_in   (sda_in)
   );

   always #5 clk = ~clk;

   // Bus monitor and slave responder, working on the falling clock edge.
   always @(negedge clk) begin
      logic [8:0] sh;
      scl_prev <= scl;
      sda_prev <= sda_line;
      if (rst) begin
         mon_act    <= 1'b0;
         slave_pull <= 1'b0;
      end else if (scl && scl_prev && sda_prev && !sda_line) begin
         bus_log.push_back(EV_START);
         mon_act    <= 1'b1;
         mon_bit    <= 0;
         mon_byte   <= 0;
         mon_read   <= 1'b0;
         slave_pull <= 1'b0;
      end else if (scl && scl_prev && !sda_prev && sda_line) begin
         bus_log.push_back(EV_STOP);
         mon_act    <= 1'b0;
         slave_pull <= 1'b0;
      end else if (mon_act && scl && !scl_prev) begin
         sh = {mon_sh[7:0], sda_line};
         mon_sh <= sh;
         if (mon_bit == 8) begin
            bus_log.push_back(int'(sh));
            if (mon_byte == 0) mon_read <= sh[1];
            mon_byte <= mon_byte + 1;
            mon_bit  <= 0;
         end else begin
            mon_bit <= mon_bit + 1;
         end
      end else if (mon_act && !scl && scl_prev) begin
         if (mon_bit == 8)
            slave_pull <= (mon_read && mon_byte == 1) ? 1'b0 : (mon_byte != slave_nack_byte);
         else if (mon_read && mon_byte == 1)
            slave_pull <= ~slave_rd_byte[7 - mon_bit];
         else
            slave_pull <= 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int log_at(input int i);
      if (i < bus_log.size()) return bus_log[i];
      return -1;
   endfunction

   // One upstream-style request: ena held until busy, then dropped.
   // cyc returns the number of cycles busy was high.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                          input logic r, input bit pulse, output int n);
      int w;
      addr = a; sub_addr = s; data_wr = d; rw = r; ena = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!busy && w < 10);
      ena = 1'b0;
      ack_after_acc = ack_err;
      check_val("busy_rise", busy, 1);
      n = 0;
      if (!busy) return;
      n = 1;
      while (n < 2000) begin
         @(negedge clk);
         if (pulse && n == 100) begin
            ena = 1'b1; addr = 8'h42; sub_addr = 8'h55; data_wr = 8'hAA; rw = 1'b1;
         end
         if (pulse && n == 102) ena = 1'b0;
         if (!busy) break;
         n++;
      end
      check_val("busy_fall", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ena = 1'b0; addr = 8'h00; sub_addr = 8'h00; data_wr = 8'h00; rw = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_ack_err", ack_err, 0);
      check_val("rst_data_rd", data_rd, 8'h00);
      check_val("rst_scl", scl, 1);
      check_val("rst_sda_oe", sda_oe, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // register write C0 / 11 / 04
      bus_log.delete();
      run_txn(8'hC0, 8'h11, 8'h04, 1'b0, 1'b0, cyc);
      check_val("wr_cycles", cyc, 464);
      check_val("wr_log_size", bus_log.size(), 5);
      check_val("wr_start", log_at(0), EV_START);
      check_val("wr_addr", log_at(1), 'h180);
      check_val("wr_sub", log_at(2), 'h022);
      check_val("wr_data", log_at(3), 'h008);
      check_val("wr_stop", log_at(4), EV_STOP);
      check_val("wr_data_rd", data_rd, 8'h00);
      check_val("wr_ack_err", ack_err, 0);

      // register read C0 / 0A, slave returns 7F
      slave_rd_byte = 8'h7F;
      bus_log.delete();
      run_txn(8'hC0, 8'h0A, 8'h00, 1'b1, 1'b0, cyc);
      check_val("rd_cycles", cyc, 640);
      check_val("rd_log_size", bus_log.size(), 8);
      check_val("rd_start1", log_at(0), EV_START);
      check_val("rd_addr_w", log_at(1), 'h180);
      check_val("rd_sub", log_at(2), 'h014);
      check_val("rd_stop1", log_at(3), EV_STOP);
      check_val("rd_start2", log_at(4), EV_START);
      check_val("rd_addr_r", log_at(5), 'h182);
      check_val("rd_byte_mack", log_at(6), 'h0FF);
      check_val("rd_stop2", log_at(7), EV_STOP);
      check_val("rd_data_rd", data_rd, 8'h7F);

      // slave NACKs the address byte
      slave_nack_byte = 0;
      bus_log.delete();
      run_txn(8'hC0, 8'h11, 8'h04, 1'b0, 1'b0, cyc);
      check_val("nack_addr_bit", log_at(1), 'h181);
`ifdef SCCB_ACK_CHECK_EN
      check_val("nack_cycles", cyc, 176);
      check_val("nack_ack_err", ack_err, 1);
      check_val("nack_log_size", bus_log.size(), 3);
      check_val("nack_stop", log_at(2), EV_STOP);
`else
      check_val("nack_cycles", cyc, 464);
      check_val("nack_ack_err", ack_err, 0);
      check_val("nack_log_size", bus_log.size(), 5);
`endif
      check_val("nack_data_rd", data_rd, 8'h7F);
      slave_nack_byte = -1;

      // 8 back-to-back writes with ena pulses during busy
      bus_log.delete();
      for (int i = 0; i < 8; i++) begin
         run_txn(8'hC0, 8'h30 + 8'(i), 8'h20 + 8'(i), 1'b0, 1'b1, cyc);
         if (i == 0) check_val("b2b_ack_err_clr", ack_after_acc, 0);
         check_val("b2b_cycles", cyc, 464);
      end
      repeat (2) @(negedge clk);
      check_val("b2b_log_size", bus_log.size(), 40);
      for (int i = 0; i < 8; i++) begin
         check_val("b2b_start", log_at(5*i), EV_START);
         check_val("b2b_sub", log_at(5*i + 2), (32'h30 + i) << 1);
         check_val("b2b_data", log_at(5*i + 3), (32'h20 + i) << 1);
         check_val("b2b_stop", log_at(5*i + 4), EV_STOP);
      end
      check_val("b2b_busy_idle", busy, 0);
      check_val("b2b_data_rd", data_rd, 8'h7F);

      // reset during the 5th bit of sub_addr
      run_txn_abort();
      check_val("mid_rst_scl", scl, 1);
      check_val("mid_rst_sda_oe", sda_oe, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_ack_err", ack_err, 0);
      check_val("mid_rst_data_rd", data_rd, 8'h00);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      bus_log.delete();
      run_txn(8'hC0, 8'h11, 8'h04, 1'b0, 1'b0, cyc);
      check_val("post_rst_cycles", cyc, 464);
      check_val("post_rst_log_size", bus_log.size(), 5);
      check_val("post_rst_data", log_at(3), 'h008);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Starts a write and asserts rst mid sub_addr; returns one cycle after the reset edge.
   task automatic run_txn_abort();
      int w;
      addr = 8'hC0; sub_addr = 8'h11; data_wr = 8'h04; rw = 1'b0; ena = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!busy && w < 10);
      ena = 1'b0;
      check_val("abort_busy_rise", busy, 1);
      repeat (229) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

endmodule
